march_seq_ctrl: RTL and testbench
=================================

MARCH_SEQ_CTRL -- requirements
Module: march_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM address width (256 words).
REQ-002 Parameter DATA_W, default 4, SRAM word width.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a March C- run.
REQ-006 mem_addr  output  ADDR_W  SRAM address for the current operation.
REQ-007 mem_we  output  1  SRAM write enable; 1 = write, 0 = read.
REQ-008 mem_wdata  output  DATA_W  SRAM write data (background pattern).
REQ-009 mem_rdata  input  DATA_W  SRAM read data, synchronous, valid one cycle after a read address.
REQ-010 busy  output  1  high while a run is in progress (RUN or FLUSH).
REQ-011 done  output  1  high while in DONE; held until the next start or Reset.
REQ-012 go_nogo  output  1  1 = no mismatch so far, 0 = at least one mismatch.
REQ-013 fail_addr  output  ADDR_W  address of the first mismatching read.
REQ-014 fail_elem  output  3  March element index (0-5) of the first mismatch.

Function
REQ-015 The algorithm is March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0). Data 0 = all-zeros, 1 = all-ones on DATA_W bits.
REQ-016 FSM states are IDLE, RUN, FLUSH, DONE. IDLE->RUN on start; RUN->FLUSH after the last E5 op; FLUSH->DONE after 1 cycle; DONE->RUN on start.
REQ-017 RUN issues exactly one SRAM operation per cycle, with no idle cycles between operations or elements.
REQ-018 In two-op elements, read and write to the same address occupy consecutive cycles (read first), then the address advances.
REQ-019 Up elements count 0..2^ADDR_W-1; down elements count 2^ADDR_W-1..0; the element ends on the terminal address, with no wrap.
REQ-020 A run is 2560 ops (256 + 4*512 + 256); op n (n = 0..2559) is driven in cycle n+1 after the start edge.
REQ-021 The expected value and a compare-valid flag are registered with each read; mem_rdata is compared in the following cycle. The last E5 read is compared during FLUSH.
REQ-022 On the first mismatch in a run: go_nogo clears to 0, and fail_addr/fail_elem capture that read; later mismatches do not overwrite them.
REQ-023 start is ignored while busy; start in IDLE or DONE clears go_nogo to 1, clears fail_addr/fail_elem to 0, and begins E0 at address 0.
REQ-024 Outside RUN: mem_we=0, mem_addr=0, mem_wdata=0; no compare is performed.
REQ-025 done rises exactly 2562 cycles after the start edge and is never high together with busy.

Reset
REQ-026 Reset forces IDLE, busy=0, done=0, go_nogo=1, fail_addr=0, fail_elem=0, mem_we=0, mem_addr=0, mem_wdata=0, and clears the compare pipeline.
REQ-027 Reset mid-run aborts the run immediately; no write is issued after assertion, and a pending compare is discarded.

Structure
REQ-028 Package march_pkg holds the state enum, element encoding (E0-E5), per-element direction/op/data table, and ADDR_W/DATA_W defaults.
REQ-029 One sub-module, march_addr_gen: a loadable up/down address counter with terminal-count output; the FSM, op sequencing, and compare/capture stay in march_seq_ctrl.

Verification
REQ-030 Fault-free behavioural SRAM, start pulse -> exactly 2560 ops in order; done at cycle 2562; go_nogo=1.
REQ-031 Bit 0 stuck-at-0 at address 0x3A -> first mismatch in E2 r1; fail_addr=0x3A, fail_elem=2, go_nogo=0; run still completes.
REQ-032 Coupling fault: write 1 to 0x10 flips 0x11 -> fail_addr=0x11, fail_elem=1; a second injected fault at 0xF0 does not change the capture.
REQ-033 Mismatch only on the last E5 read (address 0xFF) -> detected in FLUSH; fail_addr=0xFF, fail_elem=5, done at cycle 2562.
REQ-034 Reset asserted at op 700 -> next cycle IDLE, mem_we=0, go_nogo=1; a subsequent start yields a full clean run.
REQ-035 start re-pulsed at op 100 and again in DONE -> first is ignored; second restarts with go_nogo=1 and E0 at address 0.

Source files
------------

// File: rtl/march_pkg.sv
// March C- sequencer shared types: FSM states, element encoding and the
// per-element direction/operation/data table.
package march_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    typedef struct packed {
        logic up;      // 1 = ascending addresses
        logic has_rd;  // element starts with a read at each address
        logic has_wr;  // element ends with a write at each address
        logic rd_one;  // expected read data is all-ones
        logic wr_one;  // write data is all-ones
    } elem_cfg_t;

    function automatic logic elem_is_up(elem_e e);
        return !(e == E3 || e == E4);
    endfunction

    function automatic elem_cfg_t elem_cfg(elem_e e);
        elem_cfg_t c;
        c = '0;
        c.up = elem_is_up(e);
        case (e)
            E0: begin c.has_wr = 1'b1; end
            E1: begin c.has_rd = 1'b1; c.has_wr = 1'b1; c.wr_one = 1'b1; end
            E2: begin c.has_rd = 1'b1; c.has_wr = 1'b1; c.rd_one = 1'b1; end
            E3: begin c.has_rd = 1'b1; c.has_wr = 1'b1; c.wr_one = 1'b1; end
            E4: begin c.has_rd = 1'b1; c.has_wr = 1'b1; c.rd_one = 1'b1; end
            E5: begin c.has_rd = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter; tc flags the terminal address of the
// current direction so the element can end without wrapping.
module march_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  logic              up,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    // Address register: load wins over count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     addr <= '0;
        else if (load) addr <= load_val;
        else if (en)   addr <= up ? addr + 1'b1 : addr - 1'b1;
    end

    // Terminal count for the direction being walked.
    always_comb begin
        tc = up ? (addr == '1) : (addr == '0);
    end

endmodule

// File: rtl/march_seq_ctrl.sv
// March C- SRAM test sequencer: one SRAM op per cycle while RUN, a one-cycle
// FLUSH for the last read's compare, and a sticky first-failure capture.
module march_seq_ctrl
    import march_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              go_nogo,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_e            state, state_nxt;
    elem_e             elem, elem_nxt;
    logic              phase, phase_nxt;   // 1 = read at this address already issued
    elem_cfg_t         cfg;
    logic              op_rd, op_wr, last_at_addr;
    logic              ag_load, ag_en;
    logic [ADDR_W-1:0] ag_val, addr;
    logic              tc;

    logic              cmp_vld;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] cmp_addr;
    elem_e             cmp_elem;
    logic              mismatch;
    logic              start_ok;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (ag_load),
        .load_val(ag_val),
        .en      (ag_en),
        .up      (cfg.up),
        .addr    (addr),
        .tc      (tc)
    );

    // State, element and per-address phase registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            elem  <= E0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state, op sequencing and address-counter control.
    always_comb begin
        state_nxt    = state;
        elem_nxt     = elem;
        phase_nxt    = phase;
        ag_load      = 1'b0;
        ag_val       = '0;
        ag_en        = 1'b0;
        cfg          = elem_cfg(elem);
        op_rd        = 1'b0;
        op_wr        = 1'b0;
        last_at_addr = 1'b0;
        start_ok     = 1'b0;
        if (state == RUN) begin
            op_rd        = cfg.has_rd && !phase;
            op_wr        = cfg.has_wr && (phase || !cfg.has_rd);
            last_at_addr = op_wr || (op_rd && !cfg.has_wr);
        end
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = RUN;
                    elem_nxt  = E0;
                    phase_nxt = 1'b0;
                    ag_load   = 1'b1;
                    ag_val    = '0;
                end
            end
            RUN: begin
                if (!last_at_addr) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (!tc) begin
                        ag_en = 1'b1;
                    end else if (elem == E5) begin
                        state_nxt = FLUSH;
                    end else begin
                        elem_nxt = elem_e'(elem + 3'd1);
                        ag_load  = 1'b1;
                        ag_val   = elem_is_up(elem_nxt) ? '0 : '1;
                    end
                end
            end
            FLUSH: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM and status outputs; everything quiet outside RUN.
    always_comb begin
        mem_we    = op_wr;
        mem_addr  = (state == RUN) ? addr : '0;
        mem_wdata = (op_wr && cfg.wr_one) ? '1 : '0;
        busy      = (state == RUN) || (state == FLUSH);
        done      = (state == DONE);
        mismatch  = cmp_vld && (mem_rdata != exp_q);
    end

    // Compare pipeline: register what each read should return, check next cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cmp_vld  <= 1'b0;
            exp_q    <= '0;
            cmp_addr <= '0;
            cmp_elem <= E0;
        end else begin
            cmp_vld  <= op_rd;
            exp_q    <= cfg.rd_one ? '1 : '0;
            cmp_addr <= addr;
            cmp_elem <= elem;
        end
    end

    // Sticky first-failure capture, cleared by an accepted start.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            go_nogo   <= 1'b1;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (start_ok) begin
            go_nogo   <= 1'b1;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (mismatch && go_nogo) begin
            go_nogo   <= 1'b0;
            fail_addr <= cmp_addr;
            fail_elem <= cmp_elem;
        end
    end

endmodule

// File: tb/tb_march_seq_ctrl.sv
// Directed bench for march_seq_ctrl with a behavioural SRAM and fault hooks.
module tb_march_seq_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 4;
    localparam int N    = 256;
    localparam int NOPS = 2560;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, done, go_nogo;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int errs   = 0;
    int checks = 0;

    // expected op stream
    logic [AW-1:0] e_addr [NOPS];
    logic          e_we   [NOPS];
    logic [DW-1:0] e_wd   [NOPS];

    // fault controls
    bit            sa_en   = 1'b0;
    logic [AW-1:0] sa_addr = '0;
    bit            cf_en   = 1'b0;
    bit            last_en = 1'b0;
    int            ff_rd   = 0;
    logic [DW-1:0] mem [N];

    always #5 Clock = ~Clock;

    march_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .go_nogo  (go_nogo),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem)
    );

    function automatic logic [DW-1:0] sram_rd(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (sa_en && a == sa_addr) r[0] = 1'b0;
        if (last_en && a == 8'hFF && ff_rd == 4) r = ~r;
        return r;
    endfunction

    // synchronous SRAM: stuck-at bit 0, 0x10->0x11 coupling, last-read corruption
    always @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            if (cf_en && mem_addr == 8'h10 && mem_wdata == 4'hF) mem[8'h11] <= ~mem[8'h11];
        end else begin
            mem_rdata <= sram_rd(mem[mem_addr], mem_addr);
            if (mem_addr == 8'hFF) ff_rd <= ff_rd + 1;
        end
        if (start && !busy) ff_rd <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start, follow the run cycle by cycle. Optionally re-pulse start at
    // op 'repulse' or return early at op 'abort_at'.
    task automatic run(input bit chk_ops, input int repulse, input int abort_at,
                       output int done_cyc, output logic go_flush);
        bit overlap;
        done_cyc = -1;
        go_flush = 1'bx;
        overlap  = 1'b0;
        @(negedge Clock); start = 1'b1;
        for (int cyc = 1; cyc <= NOPS + 10; cyc++) begin
            @(negedge Clock);
            start = (repulse >= 0 && cyc == repulse + 1);
            if (abort_at >= 0 && cyc == abort_at + 1) return;
            if (busy && done) overlap = 1'b1;
            if (cyc == 1) begin
                chk("start_go_nogo",   32'(go_nogo),   32'd1);
                chk("start_fail_addr", 32'(fail_addr), 32'd0);
                chk("start_fail_elem", 32'(fail_elem), 32'd0);
                chk("start_busy",      32'(busy),      32'd1);
            end
            if (chk_ops && cyc <= NOPS) begin
                chk("op_addr", 32'(mem_addr), 32'(e_addr[cyc-1]));
                chk("op_we",   32'(mem_we),   32'(e_we[cyc-1]));
                if (e_we[cyc-1]) chk("op_wdata", 32'(mem_wdata), 32'(e_wd[cyc-1]));
            end
            if (cyc == NOPS + 1) go_flush = go_nogo;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        chk("busy_done_excl", 32'(overlap), 32'd0);
    endtask

    int   dc;
    logic gf;

    initial begin
        // build the March C- op list
        begin
            int k;
            int a;
            k = 0;
            for (int e = 0; e < 6; e++) begin
                for (int i = 0; i < N; i++) begin
                    a = (e == 3 || e == 4) ? N - 1 - i : i;
                    if (e != 0) begin
                        e_addr[k] = AW'(a); e_we[k] = 1'b0; e_wd[k] = '0; k++;
                    end
                    if (e != 5) begin
                        e_addr[k] = AW'(a); e_we[k] = 1'b1;
                        e_wd[k] = (e == 1 || e == 3) ? 4'hF : 4'h0; k++;
                    end
                end
            end
        end

        // reset state
        repeat (2) @(negedge Clock);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_go_nogo",   32'(go_nogo),   32'd1);
        chk("rst_fail_addr", 32'(fail_addr), 32'd0);
        chk("rst_fail_elem", 32'(fail_elem), 32'd0);
        chk("rst_we",        32'(mem_we),    32'd0);
        chk("rst_addr",      32'(mem_addr),  32'd0);
        chk("rst_wdata",     32'(mem_wdata), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        // clean run with the full op stream checked
        run(1'b1, -1, -1, dc, gf);
        chk("clean_done_cyc", 32'(dc),      32'd2562);
        chk("clean_go_nogo",  32'(go_nogo), 32'd1);
        chk("clean_busy",     32'(busy),    32'd0);
        chk("clean_idle_we",  32'(mem_we),  32'd0);

        // stuck-at-0 on bit 0 at 0x3A
        sa_en = 1'b1; sa_addr = 8'h3A;
        run(1'b0, -1, -1, dc, gf);
        chk("sa_done_cyc",   32'(dc),        32'd2562);
        chk("sa_go_nogo",    32'(go_nogo),   32'd0);
        chk("sa_fail_addr",  32'(fail_addr), 32'h3A);
        chk("sa_fail_elem",  32'(fail_elem), 32'd2);
        repeat (5) @(negedge Clock);
        chk("done_held",     32'(done),      32'd1);
        chk("done_not_busy", 32'(busy),      32'd0);
        sa_en = 1'b0;

        // restart from DONE clears capture; start at op 100 is ignored
        run(1'b1, 100, -1, dc, gf);
        chk("repulse_done_cyc", 32'(dc),      32'd2562);
        chk("repulse_go_nogo",  32'(go_nogo), 32'd1);

        // coupling 0x10->0x11 plus a later stuck-at at 0xF0
        cf_en = 1'b1; sa_en = 1'b1; sa_addr = 8'hF0;
        run(1'b0, -1, -1, dc, gf);
        chk("cf_done_cyc",  32'(dc),        32'd2562);
        chk("cf_go_nogo",   32'(go_nogo),   32'd0);
        chk("cf_fail_addr", 32'(fail_addr), 32'h11);
        chk("cf_fail_elem", 32'(fail_elem), 32'd1);
        cf_en = 1'b0; sa_en = 1'b0;

        // only the last E5 read at 0xFF is wrong
        last_en = 1'b1;
        run(1'b0, -1, -1, dc, gf);
        chk("last_flush_go", 32'(gf),        32'd1);
        chk("last_done_cyc", 32'(dc),        32'd2562);
        chk("last_go_nogo",  32'(go_nogo),   32'd0);
        chk("last_fail_addr",32'(fail_addr), 32'hFF);
        chk("last_fail_elem",32'(fail_elem), 32'd5);
        last_en = 1'b0;

        // reset at op 700 of a failing run
        cf_en = 1'b1;
        run(1'b0, -1, 700, dc, gf);
        chk("pre_rst_busy",    32'(busy),    32'd1);
        chk("pre_rst_go_nogo", 32'(go_nogo), 32'd0);
        Reset = 1'b1;
        #1;
        chk("abort_busy",    32'(busy),     32'd0);
        chk("abort_we",      32'(mem_we),   32'd0);
        chk("abort_addr",    32'(mem_addr), 32'd0);
        chk("abort_go_nogo", 32'(go_nogo),  32'd1);
        chk("abort_done",    32'(done),     32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("abort_hold_we", 32'(mem_we), 32'd0);
        end
        cf_en = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        run(1'b0, -1, -1, dc, gf);
        chk("post_rst_done_cyc", 32'(dc),      32'd2562);
        chk("post_rst_go_nogo",  32'(go_nogo), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
